// File: rtl/shared_counter_arbiter_pkg.sv
// Shared types and helpers for the time-shared counter arbiter.
// The pointer width is sized for the largest supported requester count (8).
package counter_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int PTR_W   = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Inputs are one-hot or zero, so OR-ing the indices of set bits is exact.
  function automatic logic [PTR_W-1:0] onehot_to_index(input logic [MAX_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/shared_counter_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr,
// wrapping to the lowest set bit when nothing at or above the pointer is set.
module rr_arbiter
  import counter_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [PTR_W-1:0] winner_idx,
  output logic             any_req
);

  logic found;

  always_comb begin
    grant_onehot = '0;
    winner_idx   = '0;
    found        = 1'b0;
    any_req      = |req;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i] && (i >= int'(rr_ptr))) begin
        found           = 1'b1;
        grant_onehot[i] = 1'b1;
        winner_idx      = PTR_W'(i);
      end
    end
    // Wrap pass: only bits below the pointer can remain at this point.
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        found           = 1'b1;
        grant_onehot[i] = 1'b1;
        winner_idx      = PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/shared_counter_arbiter.sv
// One shared up-counter time-shared among N_REQ requesters: round-robin grant,
// count 0..limit for the owner, then a one-cycle done pulse back to it.
module shared_counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] limit,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       count
);

  state_e             state_q;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   done_q;
  logic [WIDTH-1:0]   count_q;
  logic [WIDTH-1:0]   count_d;
  logic [WIDTH-1:0]   lim_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   rr_ptr_d;

  logic [N_REQ-1:0]   arb_grant;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_any;
  logic [WIDTH-1:0]   win_lim;
  logic [MAX_REQ-1:0] grant_ext;
  logic [PTR_W-1:0]   owner_idx;
  logic               owner_req;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req          (req),
    .rr_ptr       (rr_ptr_q),
    .grant_onehot (arb_grant),
    .winner_idx   (arb_idx),
    .any_req      (arb_any)
  );

  always_comb begin
    win_lim = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == PTR_W'(i)) win_lim = limit[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    grant_ext              = '0;
    grant_ext[N_REQ-1:0]   = grant_q;
  end

  // Pointer moves just past whoever released the counter, so a requester
  // that keeps its level high is served last in the next round.
  assign owner_idx = onehot_to_index(grant_ext);
  assign rr_ptr_d  = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;
  assign owner_req = |(req & grant_q);
  assign count_d   = count_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      count_q  <= '0;
      lim_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            grant_q <= arb_grant;
            lim_q   <= win_lim;
            count_q <= '0;
            state_q <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          // Abort is checked before the terminal count so a dropped request
          // never receives a done pulse.
          if (!owner_req) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            count_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
          end else if (count_q == lim_q) begin
            state_q <= ST_DONE;
            done_q  <= grant_q;
          end else begin
            count_q <= count_d;
          end
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          done_q   <= '0;
          grant_q  <= '0;
          count_q  <= '0;
          rr_ptr_q <= rr_ptr_d;
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          done_q  <= '0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign count = count_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shared_counter_arbiter.sv
// Bench for shared_counter_arbiter: vector table, directed corner sequences,
// and randomized traffic checked against a transaction-timeline model.
module tb_shared_counter_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] limit;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   count;

  int n_vec = 0;
  int n_err = 0;
  bit use_model = 1'b0;

  int m_owner;
  int m_t;
  int m_lim;
  int m_ptr;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] limit;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   count;
  } vec_t;

  vec_t tv[$];

  shared_counter_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .limit (limit),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int eg, input int ed, input int eb, input int ec);
    chk({tag, " grant"}, 32'(grant), 32'(eg));
    chk({tag, " done"},  32'(done),  32'(ed));
    chk({tag, " busy"},  32'(busy),  32'(eb));
    chk({tag, " count"}, 32'(count), 32'(ec));
  endtask

  // Timeline model: an owner holds the counter for m_lim+1 counting cycles
  // then one done cycle; aborts and completions hand priority past the owner.
  task automatic model_edge();
    if (m_owner < 0) begin
      if (req != '0) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (m_owner < 0 && req[idx]) begin
            m_owner = idx;
            m_t     = 0;
            m_lim   = int'(limit[idx*W +: W]);
          end
        end
      end
    end else if (m_t <= m_lim) begin
      if (!req[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_t++;
      end
    end else begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
  endtask

  task automatic model_check();
    int eg, ed, eb, ec;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    ed = (m_owner >= 0 && m_t == m_lim + 1) ? (1 << m_owner) : 0;
    eb = (m_owner >= 0) ? 1 : 0;
    ec = (m_owner < 0) ? 0 : ((m_t <= m_lim) ? m_t : m_lim);
    check_out("rand", eg, ed, eb, ec);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (use_model) model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    limit = '0;
    @(negedge clk);
    @(negedge clk);
    check_out("reset", 0, 0, 0, 0);
    rst = 1'b0;
    m_owner = -1;
    m_t     = 0;
    m_lim   = 0;
    m_ptr   = 0;
  endtask

  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        if (done[i] && ($urandom % 4 != 0)) req[i] = 1'b0;
        else if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
      end else if ($urandom % 3 == 0) begin
        req[i] = 1'b1;
        limit[i*W +: W] = ($urandom % 8 == 0) ? 4'hF : 4'($urandom_range(0, 5));
      end
    end
    if ($urandom % 10 == 0) begin
      int j;
      j = $urandom_range(0, N - 1);
      limit[j*W +: W] = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    limit = '0;

    // Single request, limit 5, then limit 0 on requester 1.
    for (int c = 0; c <= 5; c++)
      tv.push_back('{4'b0001, 16'h0005, 4'b0001, 4'b0000, 1'b1, 4'(c)});
    tv.push_back('{4'b0001, 16'h0005, 4'b0001, 4'b0001, 1'b1, 4'd5});
    tv.push_back('{4'b0000, 16'h0005, 4'b0000, 4'b0000, 1'b0, 4'd0});
    tv.push_back('{4'b0000, 16'h0005, 4'b0000, 4'b0000, 1'b0, 4'd0});
    tv.push_back('{4'b0010, 16'h0000, 4'b0010, 4'b0000, 1'b1, 4'd0});
    tv.push_back('{4'b0010, 16'h0000, 4'b0010, 4'b0010, 1'b1, 4'd0});
    tv.push_back('{4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0});

    do_reset();
    foreach (tv[i]) begin
      req   = tv[i].req;
      limit = tv[i].limit;
      step();
      check_out($sformatf("vec%0d", i), int'(tv[i].grant), int'(tv[i].done),
                int'(tv[i].busy), int'(tv[i].count));
    end

    // limit 15: count reaches all-ones, no wrap, done 16 cycles after grant.
    req   = 4'b0010;
    limit = 16'h00F0;
    step();
    check_out("max c0", 2, 0, 1, 0);
    for (int c = 1; c <= 15; c++) begin
      step();
      check_out("max cnt", 2, 0, 1, c);
    end
    step();
    check_out("max done", 2, 2, 1, 15);
    req = '0;
    step();
    check_out("max idle", 0, 0, 0, 0);

    // Round-robin with 1011 held continuously, all limits 2.
    do_reset();
    limit = 16'h2222;
    req   = 4'b1011;
    begin
      int owners[4] = '{0, 1, 3, 0};
      foreach (owners[k]) begin
        int oh;
        oh = 1 << owners[k];
        step();
        check_out("rr c0", oh, 0, 1, 0);
        step();
        check_out("rr c1", oh, 0, 1, 1);
        step();
        check_out("rr c2", oh, 0, 1, 2);
        step();
        check_out("rr done", oh, oh, 1, 2);
        if (k == 3) req = '0;
        step();
        check_out("rr gap", 0, 0, 0, 0);
      end
    end

    // Abort at count 3; pointer moves past requester 2 so 3 wins next.
    limit = 16'h1900;
    req   = 4'b0100;
    step();
    check_out("abort c0", 4, 0, 1, 0);
    for (int c = 1; c <= 3; c++) begin
      step();
      check_out("abort cnt", 4, 0, 1, c);
    end
    req = 4'b1000;
    step();
    check_out("abort drop", 0, 0, 0, 0);
    req = 4'b1100;
    step();
    check_out("abort next", 8, 0, 1, 0);
    step();
    check_out("abort next c1", 8, 0, 1, 1);
    step();
    check_out("abort next done", 8, 8, 1, 1);
    req = '0;
    step();
    check_out("abort idle", 0, 0, 0, 0);

    // Asynchronous reset mid-count.
    do_reset();
    limit = 16'h0007;
    req   = 4'b0001;
    step();
    for (int c = 1; c <= 4; c++) step();
    check_out("arst pre", 1, 0, 1, 4);
    #2 rst = 1'b1;
    #1 check_out("arst async", 0, 0, 0, 0);
    #1 rst = 1'b0;
    req = 4'b0011;
    step();
    check_out("arst restart", 1, 0, 1, 0);
    req = '0;
    step();
    check_out("arst abort", 0, 0, 0, 0);

    // Limit change after grant is ignored.
    do_reset();
    limit = 16'h0003;
    req   = 4'b0001;
    step();
    check_out("lchg c0", 1, 0, 1, 0);
    limit = 16'h000C;
    for (int c = 1; c <= 3; c++) begin
      step();
      check_out("lchg cnt", 1, 0, 1, c);
    end
    step();
    check_out("lchg done", 1, 1, 1, 3);
    req = '0;
    step();
    check_out("lchg idle", 0, 0, 0, 0);

    // Randomized traffic against the timeline model.
    do_reset();
    use_model = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drive_random();
      step();
      model_check();
    end
    use_model = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
